// File: rtl/downsampler_2x2_pkg.sv
// Shared constants and the 2x2 box-average helper for the downsampler.
package downsampler_2x2_pkg;

    localparam int unsigned PIX_W          = 8;
    localparam int unsigned CNT_W          = 10;
    localparam int unsigned DEF_IN_WIDTH   = 800;
    localparam int unsigned DEF_IN_HEIGHT  = 600;
    localparam int unsigned ROUND_C        = 2;
    localparam int unsigned LB_W           = PIX_W + 1;
    localparam int unsigned SUM_W          = PIX_W + 2;

    // Four 8-bit pixels sum to at most 1020, so +2 cannot overflow SUM_W bits.
    function automatic logic [PIX_W-1:0] box_avg(input logic [SUM_W-1:0] sum);
        logic [SUM_W-1:0] w_rnd;
        w_rnd = sum + SUM_W'(ROUND_C);
        return w_rnd[SUM_W-1:2];
    endfunction

endpackage

// File: rtl/downsampler_2x2_if.sv
// Pixel stream in, FIFO write stream and status out.
interface downsampler_2x2_if;
    import downsampler_2x2_pkg::*;

    logic             valid;
    logic [PIX_W-1:0] data;
    logic             fifo_full;
    logic [PIX_W-1:0] dataout;
    logic             validout;
    logic [CNT_W-1:0] current_rowcount;
    logic [CNT_W-1:0] current_colcount;
    logic             frame_done;
    logic             overflow;

    modport master (
        output valid, data, fifo_full,
        input  dataout, validout, current_rowcount, current_colcount, frame_done, overflow
    );

    modport slave (
        input  valid, data, fifo_full,
        output dataout, validout, current_rowcount, current_colcount, frame_done, overflow
    );

endinterface

// File: rtl/downsampler_2x2_line_buffer.sv
// Simple dual-port RAM holding even-row pair sums; synchronous read, 1-cycle latency.
module downsampler_2x2_line_buffer #(
    parameter  int unsigned DEPTH  = 400,
    parameter  int unsigned DATA_W = 9,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register holds its value until the next read, serving as lb_q.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/downsampler_2x2.sv
// 2x2 box-filter decimator; frame position is tracked by counting accepted pixels.
module downsampler_2x2
    import downsampler_2x2_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
    parameter int unsigned IN_HEIGHT = DEF_IN_HEIGHT
) (
    input  logic             i_clock,
    input  logic             i_reset,
    downsampler_2x2_if.slave io_bus
);

    localparam int unsigned      LB_DEPTH = IN_WIDTH / 2;
    localparam int unsigned      LB_AW    = $clog2(LB_DEPTH);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IN_WIDTH - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IN_HEIGHT - 1);

    logic [CNT_W-1:0] r_row;
    logic [CNT_W-1:0] r_col;
    logic [PIX_W-1:0] r_hold;
    logic [PIX_W-1:0] r_dataout;
    logic             r_computed;
    logic             r_frame_done;
    logic             r_overflow;

    logic             w_odd_row;
    logic             w_odd_col;
    logic             w_lb_we;
    logic             w_lb_re;
    logic             w_fire;
    logic [LB_AW-1:0] w_lb_addr;
    logic [LB_W-1:0]  w_pair;
    logic [LB_W-1:0]  w_lb_rdata;
    logic [SUM_W-1:0] w_sum;

    assign w_odd_row = r_row[0];
    assign w_odd_col = r_col[0];
    assign w_lb_addr = r_col[LB_AW:1];
    assign w_lb_we   = io_bus.valid & ~w_odd_row & w_odd_col;
    assign w_lb_re   = io_bus.valid & w_odd_row & ~w_odd_col;
    assign w_fire    = io_bus.valid & w_odd_row & w_odd_col;
    assign w_pair    = LB_W'(r_hold) + LB_W'(io_bus.data);
    assign w_sum     = SUM_W'(w_lb_rdata) + SUM_W'(r_hold) + SUM_W'(io_bus.data);

    downsampler_2x2_line_buffer #(
        .DEPTH  (LB_DEPTH),
        .DATA_W (LB_W)
    ) u_line_buffer (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_we    (w_lb_we),
        .i_waddr (w_lb_addr),
        .i_wdata (w_pair),
        .i_re    (w_lb_re),
        .i_raddr (w_lb_addr),
        .o_rdata (w_lb_rdata)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_row        <= '0;
            r_col        <= '0;
            r_hold       <= '0;
            r_dataout    <= '0;
            r_computed   <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_computed   <= w_fire;
            // A computed pixel meeting a full FIFO is lost for good.
            if (r_computed && io_bus.fifo_full) begin
                r_overflow <= 1'b1;
            end
            if (io_bus.valid) begin
                if (!w_odd_col) begin
                    r_hold <= io_bus.data;
                end
                if (w_fire) begin
                    r_dataout <= box_avg(w_sum);
                end
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    if (r_row == ROW_LAST) begin
                        r_row        <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign io_bus.dataout          = r_dataout;
    assign io_bus.validout         = r_computed & ~io_bus.fifo_full;
    assign io_bus.current_rowcount = r_row;
    assign io_bus.current_colcount = r_col;
    assign io_bus.frame_done       = r_frame_done;
    assign io_bus.overflow         = r_overflow;

endmodule
